// File: rtl/snake_step_ctrl_if.sv
// snake_step_ctrl_if: body-store port bundle; master drives push/pop/pos_ent, slave (the store) receives them
interface snake_step_ctrl_if #(parameter int COORD_W = 3);
  logic push;
  logic pop;
  logic [2*COORD_W-1:0] pos_ent;
  modport master(output push, pop, pos_ent);
  modport slave(input push, pop, pos_ent);
endinterface

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: per-tick snake step sequencer driving the body-store push/pop ports
//   clk, reset (async, active-high); tick/dir/grow step request from game logic;
//   store (snake_step_ctrl_if.master) push/pop strobes and packed {y,x} pos_ent;
//   head_x/head_y, length, busy, step_done, game_over status.
//   Define SNAKE_WRAP_EN to make grid edges wrap instead of ending the game.
module snake_step_ctrl #(
  parameter int COORD_W = 3,
  parameter int LEN_W   = 4,
  parameter int MAX_LEN = 8,
  parameter int START_X = 3,
  parameter int START_Y = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [1:0]           dir,
  input  logic                 grow,
  snake_step_ctrl_if.master    store,
  output logic [COORD_W-1:0]   head_x,
  output logic [COORD_W-1:0]   head_y,
  output logic [LEN_W-1:0]     length,
  output logic                 busy,
  output logic                 step_done,
  output logic                 game_over
);
  typedef enum logic [2:0] {INIT, IDLE, PUSH, POP, DONE, OVER} state_t;
  state_t state;
  logic grow_q;
  logic hit;
  logic [COORD_W-1:0] nx, ny;
  always_comb begin
    nx = dir == 2'd1 ? head_x + COORD_W'(1) : dir == 2'd3 ? head_x - COORD_W'(1) : head_x;
    ny = dir == 2'd2 ? head_y + COORD_W'(1) : dir == 2'd0 ? head_y - COORD_W'(1) : head_y;
`ifdef SNAKE_WRAP_EN
    hit = 1'b0;
`else
    hit = dir == 2'd0 ? head_y == '0 : dir == 2'd1 ? head_x == '1 : dir == 2'd2 ? head_y == '1 : head_x == '0;
`endif
  end
  // Outputs are registered alongside the state they belong to, so each strobe
  // is visible for exactly the cycle its state is occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= INIT;
      store.push    <= 1'b0;
      store.pop     <= 1'b0;
      store.pos_ent <= {COORD_W'(START_Y), COORD_W'(START_X)};
      head_x        <= COORD_W'(START_X);
      head_y        <= COORD_W'(START_Y);
      length        <= '0;
      busy          <= 1'b1;
      step_done     <= 1'b0;
      game_over     <= 1'b0;
      grow_q        <= 1'b0;
    end else begin
      store.push <= 1'b0;
      store.pop  <= 1'b0;
      step_done  <= 1'b0;
      case (state)
        INIT: begin
          store.push    <= 1'b1;
          store.pos_ent <= {head_y, head_x};
          length        <= LEN_W'(1);
          busy          <= 1'b0;
          state         <= IDLE;
        end
        IDLE: if (tick) begin
          grow_q <= grow;
          if (hit) begin
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            store.push    <= 1'b1;
            store.pos_ent <= {ny, nx};
            head_x        <= nx;
            head_y        <= ny;
            busy          <= 1'b1;
            state         <= PUSH;
          end
        end
        PUSH: begin
          // a grow request at full length degrades to a normal move
          if (!grow_q || length == LEN_W'(MAX_LEN)) store.pop <= 1'b1;
          else length <= length + LEN_W'(1);
          state <= POP;
        end
        POP: begin
          step_done <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= OVER;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb_snake_step_ctrl: scoreboard bench for snake_step_ctrl
module tb_snake_step_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic [1:0] dir = 2'd0;
  logic grow = 1'b0;
  logic [2:0] head_x, head_y;
  logic [3:0] length;
  logic busy, step_done, game_over;
  int pass = 0;
  int total = 0;
  int mx, my, mlen;
  logic mover;
  typedef struct {
    logic push;
    logic pop;
    logic done;
    logic over;
    logic busy;
    logic [5:0] pos;
  } exp_t;
  exp_t q[$];
  snake_step_ctrl_if #(.COORD_W(3)) sif();
  snake_step_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .dir(dir), .grow(grow), .store(sif),
    .head_x(head_x), .head_y(head_y), .length(length), .busy(busy),
    .step_done(step_done), .game_over(game_over)
  );
  always #5 clk = ~clk;
  task automatic test_reset;
    reset = 1'b1;
    tick = 1'b0;
    @(negedge clk);
    total++; if (sif.push !== 1'b0) $display("FAIL reset_push got %b want 0", sif.push); else pass++;
    total++; if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else pass++;
    total++; if (length !== 4'd0) $display("FAIL reset_len got %0d want 0", length); else pass++;
    total++; if (game_over !== 1'b0) $display("FAIL reset_over got %b want 0", game_over); else pass++;
    total++; if (sif.pos_ent !== 6'o33) $display("FAIL reset_pos got %o want 33", sif.pos_ent); else pass++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (sif.push !== 1'b1 || sif.pos_ent !== 6'o33) $display("FAIL init_push got push=%b pos=%o want 1/33", sif.push, sif.pos_ent); else pass++;
    total++; if (length !== 4'd1 || busy !== 1'b0) $display("FAIL init_len got len=%0d busy=%b want 1/0", length, busy); else pass++;
    mx = 3; my = 3; mlen = 1; mover = 1'b0;
  endtask
  task automatic do_step(input logic [1:0] d, input logic g, input logic hold);
    int nx, ny;
    logic hit, ep;
    exp_t e;
    nx = d == 2'd1 ? mx + 1 : d == 2'd3 ? mx - 1 : mx;
    ny = d == 2'd2 ? my + 1 : d == 2'd0 ? my - 1 : my;
`ifdef SNAKE_WRAP_EN
    hit = 1'b0;
    nx = nx & 7;
    ny = ny & 7;
`else
    hit = nx < 0 || nx > 7 || ny < 0 || ny > 7;
`endif
    if (mover || hit) begin
      mover = 1'b1;
      for (int i = 0; i < 3; i++) q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
    end else begin
      ep = !g || mlen == 8;
      q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {3'(ny), 3'(nx)}});
      q.push_back('{1'b0, ep, 1'b0, 1'b0, 1'b1, 6'd0});
      q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0});
      mx = nx; my = ny;
      if (!ep) mlen++;
    end
    @(negedge clk);
    tick = 1'b1; dir = d; grow = g;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!hold) tick = 1'b0;
      e = q.pop_front();
      total++;
      if (sif.push !== e.push || sif.pop !== e.pop || step_done !== e.done || game_over !== e.over || busy !== e.busy)
        $display("FAIL step_c%0d got push=%b pop=%b done=%b over=%b busy=%b want %b %b %b %b %b",
                 i, sif.push, sif.pop, step_done, game_over, busy, e.push, e.pop, e.done, e.over, e.busy);
      else pass++;
      if (e.push) begin
        total++;
        if (sif.pos_ent !== e.pos) $display("FAIL step_pos got %o want %o", sif.pos_ent, e.pos); else pass++;
      end
    end
    if (hold) begin
      @(negedge clk);
      tick = 1'b0;
      total++; if (sif.push !== 1'b0) $display("FAIL held_tick_push got %b want 0", sif.push); else pass++;
    end
    total++;
    if (length !== 4'(mlen) || head_x !== 3'(mx) || head_y !== 3'(my))
      $display("FAIL step_state got len=%0d x=%0d y=%0d want %0d %0d %0d", length, head_x, head_y, mlen, mx, my);
    else pass++;
  endtask
  task automatic test_step_right;
    do_step(2'd1, 1'b0, 1'b0);
  endtask
  task automatic test_grow;
    do_step(2'd0, 1'b1, 1'b0);
    do_step(2'd0, 1'b1, 1'b1);
    do_step(2'd3, 1'b1, 1'b0);
  endtask
  task automatic test_saturate;
    for (int i = 0; i < 4; i++) do_step(2'd2, 1'b1, 1'b0);
    total++; if (length !== 4'd8) $display("FAIL grow_to_max got %0d want 8", length); else pass++;
    do_step(2'd3, 1'b1, 1'b0);
  endtask
  task automatic test_edge;
    for (int i = 0; i < 8; i++) do_step(2'd1, 1'b0, 1'b0);
`ifdef SNAKE_WRAP_EN
    total++; if (game_over !== 1'b0) $display("FAIL wrap_over got %b want 0", game_over); else pass++;
`else
    total++; if (game_over !== 1'b1 || busy !== 1'b0) $display("FAIL edge_over got over=%b busy=%b want 1/0", game_over, busy); else pass++;
`endif
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    tick = 1'b1; dir = 2'd0; grow = 1'b0;
    @(negedge clk);
    tick = 1'b0;
    total++; if (sif.push !== 1'b1) $display("FAIL mid_pre_push got %b want 1", sif.push); else pass++;
    reset = 1'b1;
    #1;
    total++; if (sif.push !== 1'b0 || sif.pop !== 1'b0) $display("FAIL mid_drop got push=%b pop=%b want 0/0", sif.push, sif.pop); else pass++;
    total++; if (length !== 4'd0 || head_x !== 3'd3 || head_y !== 3'd3) $display("FAIL mid_state got len=%0d x=%0d y=%0d want 0 3 3", length, head_x, head_y); else pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (sif.push !== 1'b1 || sif.pos_ent !== 6'o33 || length !== 4'd1) $display("FAIL mid_reinit got push=%b pos=%o len=%0d want 1 33 1", sif.push, sif.pos_ent, length); else pass++;
  endtask
  initial begin
    test_reset;
    test_step_right;
    test_grow;
    test_saturate;
    test_edge;
    test_reset;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
